// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA sprite controller slice:
//   - clog2 helper used to size the pixel/line counters
//   - default 640x480@60 timing constants and the derived line/frame totals
//   - bit positions of the b/g/r fields inside a packed {b,g,r} colour word
//   - per-pixel control flags carried down the colour pipeline
// -----------------------------------------------------------------------------
package vga_pkg;

  // Number of bits needed to hold the values 0..value-1 (minimum 1).
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Default 640x480@60 timing (25.175 MHz pixel clock).
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_H_TOT = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOT = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // Field positions inside a 24-bit {b,g,r} colour word.
  localparam int BGR_B_HI = 23;
  localparam int BGR_B_LO = 16;
  localparam int BGR_G_HI = 15;
  localparam int BGR_G_LO = 8;
  localparam int BGR_R_HI = 7;
  localparam int BGR_R_LO = 0;

  // Per-pixel flags that travel alongside the colour data.
  typedef struct packed {
    logic hs_n;  // horizontal sync, active-low
    logic vs_n;  // vertical sync, active-low
    logic vis;   // pixel lies in the visible area
    logic hit;   // pixel lies inside the sprite rectangle
  } pix_flags_t;

  localparam pix_flags_t FLAGS_RST = '{hs_n: 1'b1, vs_n: 1'b1, vis: 1'b0, hit: 1'b0};

endpackage

// File: rtl/vga_sprite_controller_timing.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Free-running horizontal/vertical counters for a parametrised VGA raster.
// Ports:
//   iVGA_CLK      pixel clock
//   iRST_n        asynchronous active-low reset (counters to 0)
//   hcnt_o        pixel counter, 0..H_TOT-1
//   vcnt_o        line counter, 0..V_TOT-1, advances when hcnt wraps
//   hs_n_o        horizontal sync for the current counter state, active-low
//   vs_n_o        vertical sync for the current counter state, active-low
//   visible_o     current counter state is inside the visible area
//   frame_tick_o  single-cycle strobe on the last pixel of the last line
// All outputs are decoded from the counter registers (stage 0).
// -----------------------------------------------------------------------------
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int XW       = clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
  parameter int YW       = clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic          iVGA_CLK,
  input  logic          iRST_n,
  output logic [XW-1:0] hcnt_o,
  output logic [YW-1:0] vcnt_o,
  output logic          hs_n_o,
  output logic          vs_n_o,
  output logic          visible_o,
  output logic          frame_tick_o
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic [XW-1:0] hcnt_q, hcnt_d;
  logic [YW-1:0] vcnt_q, vcnt_d;
  logic          h_last, v_last;

  assign h_last = (hcnt_q == XW'(H_TOT - 1));
  assign v_last = (vcnt_q == YW'(V_TOT - 1));

  always_comb begin
    hcnt_d = h_last ? '0 : hcnt_q + XW'(1);
    vcnt_d = vcnt_q;
    if (h_last) vcnt_d = v_last ? '0 : vcnt_q + YW'(1);
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  assign hcnt_o       = hcnt_q;
  assign vcnt_o       = vcnt_q;
  assign visible_o    = (hcnt_q < XW'(H_ACTIVE)) && (vcnt_q < YW'(V_ACTIVE));
  assign hs_n_o       = !((hcnt_q >= XW'(H_ACTIVE + H_FP)) &&
                          (hcnt_q <  XW'(H_ACTIVE + H_FP + H_SYNC)));
  assign vs_n_o       = !((vcnt_q >= YW'(V_ACTIVE + V_FP)) &&
                          (vcnt_q <  YW'(V_ACTIVE + V_FP + V_SYNC)));
  assign frame_tick_o = h_last && v_last;

endmodule

// File: rtl/vga_sprite_controller.sv
// -----------------------------------------------------------------------------
// vga_sprite_controller
// VGA raster controller that reads a full-screen indexed image from an external
// ROM, maps it through an external palette ROM, and overlays a solid-colour
// rectangular sprite moved by four push buttons.
// Ports:
//   iVGA_CLK, iRST_n                pixel clock, async active-low reset
//   moveUp/moveDown/moveLeft/moveRight  raw button levels (asynchronous)
//   img_addr  -> / img_index <-     image ROM; data must be present by the
//                                   rising edge after img_addr changes
//   pal_addr  -> / pal_bgr   <-     palette ROM; same one-clock turnaround
//   oHS, oVS                        syncs, active-low
//   oBLANK_n                        high for visible pixels
//   b_data, g_data, r_data          pixel colour
// The colour path is three clocks deep; syncs and blank are delayed to match.
// -----------------------------------------------------------------------------
module vga_sprite_controller
  import vga_pkg::*;
#(
  parameter int          H_ACTIVE = DEF_H_ACTIVE,
  parameter int          H_FP     = DEF_H_FP,
  parameter int          H_SYNC   = DEF_H_SYNC,
  parameter int          H_BP     = DEF_H_BP,
  parameter int          V_ACTIVE = DEF_V_ACTIVE,
  parameter int          V_FP     = DEF_V_FP,
  parameter int          V_SYNC   = DEF_V_SYNC,
  parameter int          V_BP     = DEF_V_BP,
  parameter int          ADDR_W   = 19,
  parameter int          IDX_W    = 8,
  parameter int          SPR_W    = 32,
  parameter int          SPR_H    = 32,
  parameter int          STEP     = 4,
  parameter int          INIT_X   = 304,
  parameter int          INIT_Y   = 224,
  parameter logic [23:0] SPR_BGR  = 24'h0000FF
) (
  input  logic              iVGA_CLK,
  input  logic              iRST_n,
  input  logic              moveUp,
  input  logic              moveDown,
  input  logic              moveLeft,
  input  logic              moveRight,
  output logic [ADDR_W-1:0] img_addr,
  input  logic [IDX_W-1:0]  img_index,
  output logic [IDX_W-1:0]  pal_addr,
  input  logic [23:0]       pal_bgr,
  output logic              oHS,
  output logic              oVS,
  output logic              oBLANK_n,
  output logic [7:0]        b_data,
  output logic [7:0]        g_data,
  output logic [7:0]        r_data
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int XW    = clog2(H_TOT);
  localparam int YW    = clog2(V_TOT);
  localparam int X_MAX = H_ACTIVE - SPR_W;
  localparam int Y_MAX = V_ACTIVE - SPR_H;

  // ---------------- stage 0: raster counters ----------------
  logic [XW-1:0] hcnt;
  logic [YW-1:0] vcnt;
  logic          hs_n, vs_n, visible, frame_tick;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .XW(XW), .YW(YW)
  ) u_timing (
    .iVGA_CLK    (iVGA_CLK),
    .iRST_n      (iRST_n),
    .hcnt_o      (hcnt),
    .vcnt_o      (vcnt),
    .hs_n_o      (hs_n),
    .vs_n_o      (vs_n),
    .visible_o   (visible),
    .frame_tick_o(frame_tick)
  );

  // ---------------- button synchroniser: {up, down, left, right} ----------------
  logic [3:0] btn_meta_q, btn_sync_q;
  logic       up, down, left, right;

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      btn_meta_q <= '0;
      btn_sync_q <= '0;
    end else begin
      btn_meta_q <= {moveUp, moveDown, moveLeft, moveRight};
      btn_sync_q <= btn_meta_q;
    end
  end

  assign {up, down, left, right} = btn_sync_q;

  // ---------------- sprite position, updated only at frame_tick ----------------
  logic [XW-1:0] cur_x_q, cur_x_d;
  logic [YW-1:0] cur_y_q, cur_y_d;
  // One extra bit so that a step below zero shows up as a set top bit.
  logic [XW:0]   x_dec, x_inc;
  logic [YW:0]   y_dec, y_inc;

  always_comb begin
    x_dec   = {1'b0, cur_x_q} - (XW+1)'(STEP);
    x_inc   = {1'b0, cur_x_q} + (XW+1)'(STEP);
    y_dec   = {1'b0, cur_y_q} - (YW+1)'(STEP);
    y_inc   = {1'b0, cur_y_q} + (YW+1)'(STEP);
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    if (frame_tick) begin
      if (left && !right)
        cur_x_d = x_dec[XW] ? '0 : x_dec[XW-1:0];
      else if (right && !left)
        cur_x_d = (x_inc > (XW+1)'(X_MAX)) ? XW'(X_MAX) : x_inc[XW-1:0];
      if (up && !down)
        cur_y_d = y_dec[YW] ? '0 : y_dec[YW-1:0];
      else if (down && !up)
        cur_y_d = (y_inc > (YW+1)'(Y_MAX)) ? YW'(Y_MAX) : y_inc[YW-1:0];
    end
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      cur_x_q <= XW'(INIT_X);
      cur_y_q <= YW'(INIT_Y);
    end else begin
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
    end
  end

  // ---------------- stage 0 decode ----------------
  pix_flags_t    flags0;
  logic [ADDR_W-1:0] addr_lin;

  assign addr_lin = ADDR_W'(32'(vcnt) * 32'(H_ACTIVE) + 32'(hcnt));

  always_comb begin
    flags0.hs_n = hs_n;
    flags0.vs_n = vs_n;
    flags0.vis  = visible;
    flags0.hit  = ({1'b0, hcnt} >= {1'b0, cur_x_q}) &&
                  ({1'b0, hcnt} <  {1'b0, cur_x_q} + (XW+1)'(SPR_W)) &&
                  ({1'b0, vcnt} >= {1'b0, cur_y_q}) &&
                  ({1'b0, vcnt} <  {1'b0, cur_y_q} + (YW+1)'(SPR_H));
  end

  // ---------------- colour pipeline ----------------
  logic [ADDR_W-1:0] img_addr_q;
  logic [IDX_W-1:0]  pal_addr_q;
  pix_flags_t        flags1_q, flags2_q, flags3_q;
  logic [23:0]       bgr_q;

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      img_addr_q <= '0;
      pal_addr_q <= '0;
      flags1_q   <= FLAGS_RST;
      flags2_q   <= FLAGS_RST;
      flags3_q   <= FLAGS_RST;
      bgr_q      <= '0;
    end else begin
      // Stage 1: the address only advances inside the visible area, so the ROM
      // sees a stable address during blanking.
      if (visible) img_addr_q <= addr_lin;
      flags1_q <= flags0;
      // Stage 2: image index is back from the ROM and becomes the palette address.
      pal_addr_q <= img_index;
      flags2_q   <= flags1_q;
      // Stage 3: palette colour is back; apply blanking and sprite overlay.
      flags3_q <= flags2_q;
      if (!flags2_q.vis)     bgr_q <= '0;
      else if (flags2_q.hit) bgr_q <= SPR_BGR;
      else                   bgr_q <= pal_bgr;
    end
  end

  assign img_addr = img_addr_q;
  assign pal_addr = pal_addr_q;
  assign oHS      = flags3_q.hs_n;
  assign oVS      = flags3_q.vs_n;
  assign oBLANK_n = flags3_q.vis;
  assign b_data   = bgr_q[BGR_B_HI:BGR_B_LO];
  assign g_data   = bgr_q[BGR_G_HI:BGR_G_LO];
  assign r_data   = bgr_q[BGR_R_HI:BGR_R_LO];

endmodule

// File: tb/tb_vga_sprite_controller.sv
// -----------------------------------------------------------------------------
// Testbench for vga_sprite_controller on a reduced 16x12 raster so that many
// frames fit in a short run. A reference model tracks the raster and sprite
// position and pushes the expected {HS,VS,BLANK_n,b,g,r} for every pixel clock;
// the entry is popped and compared when the DUT emits that pixel. The image ROM
// returns index = addr[7:0], the palette returns {idx, ~idx, idx}; both latch on
// the falling edge so data is ready by the next rising edge.
// -----------------------------------------------------------------------------
module tb_vga_sprite_controller;

  localparam int HA = 16, HFP = 2, HSW = 3, HBP = 3;
  localparam int VA = 12, VFP = 1, VSW = 2, VBP = 2;
  localparam int HT = HA + HFP + HSW + HBP;  // 24
  localparam int VT = VA + VFP + VSW + VBP;  // 17
  localparam int AW = 8, IW = 8;
  localparam int SW = 4, SH = 3, STEP = 2, IX = 7, IY = 4;
  localparam logic [23:0] SPR = 24'h0000FF;
  localparam int BOUND = 2 * HT * VT;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic mv_up = 1'b0, mv_down = 1'b0, mv_left = 1'b0, mv_right = 1'b0;
  logic [AW-1:0] img_addr;
  logic [IW-1:0] img_index = '0;
  logic [IW-1:0] pal_addr;
  logic [23:0]   pal_bgr = '0;
  logic          oHS, oVS, oBLANK_n;
  logic [7:0]    b_data, g_data, r_data;

  vga_sprite_controller #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .ADDR_W(AW), .IDX_W(IW), .SPR_W(SW), .SPR_H(SH), .STEP(STEP),
    .INIT_X(IX), .INIT_Y(IY), .SPR_BGR(SPR)
  ) dut (
    .iVGA_CLK (clk),
    .iRST_n   (rst_n),
    .moveUp   (mv_up),
    .moveDown (mv_down),
    .moveLeft (mv_left),
    .moveRight(mv_right),
    .img_addr (img_addr),
    .img_index(img_index),
    .pal_addr (pal_addr),
    .pal_bgr  (pal_bgr),
    .oHS      (oHS),
    .oVS      (oVS),
    .oBLANK_n (oBLANK_n),
    .b_data   (b_data),
    .g_data   (g_data),
    .r_data   (r_data)
  );

  // External ROM models.
  always @(negedge clk) img_index <= img_addr[7:0];
  always @(negedge clk) pal_bgr   <= {pal_addr, ~pal_addr, pal_addr};

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [36:0] exp_q[$];  // {h[4:0], v[4:0], hs, vs, blank_n, b, g, r}
  int m_h = 0, m_v = 0, m_x = IX, m_y = IY, m_frames = 0;
  int pop_h = -1, pop_v = -1;

  function automatic logic [26:0] exp_out(int h, int v, int x, int y);
    logic vis, hit, hs, vs;
    logic [7:0] idx;
    logic [23:0] bgr;
    vis = (h < HA) && (v < VA);
    hit = (h >= x) && (h < x + SW) && (v >= y) && (v < y + SH);
    hs  = !((h >= HA + HFP) && (h < HA + HFP + HSW));
    vs  = !((v >= VA + VFP) && (v < VA + VFP + VSW));
    idx = 8'((v * HA + h) % 256);
    if (!vis)     bgr = 24'h0;
    else if (hit) bgr = SPR;
    else          bgr = {idx, ~idx, idx};
    return {hs, vs, vis, bgr};
  endfunction

  always begin
    logic [36:0] ent;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_h = 0; m_v = 0; m_x = IX; m_y = IY;
      pop_h = -1; pop_v = -1;
      exp_q.delete();
    end else begin
      exp_q.push_back({5'(m_h), 5'(m_v), exp_out(m_h, m_v, m_x, m_y)});
      if (m_h == HT - 1 && m_v == VT - 1) begin
        if (mv_left && !mv_right)      m_x = (m_x >= STEP) ? m_x - STEP : 0;
        else if (mv_right && !mv_left) m_x = (m_x + STEP <= HA - SW) ? m_x + STEP : HA - SW;
        if (mv_up && !mv_down)         m_y = (m_y >= STEP) ? m_y - STEP : 0;
        else if (mv_down && !mv_up)    m_y = (m_y + STEP <= VA - SH) ? m_y + STEP : VA - SH;
        m_frames++;
      end
      if (m_h == HT - 1) begin
        m_h = 0;
        m_v = (m_v == VT - 1) ? 0 : m_v + 1;
      end else begin
        m_h++;
      end
      // Three entries outstanding means the oldest one is on the outputs now.
      if (exp_q.size() == 3) begin
        ent   = exp_q.pop_front();
        pop_h = int'(ent[36:32]);
        pop_v = int'(ent[31:27]);
        n_checks++;
        if ({oHS, oVS, oBLANK_n, b_data, g_data, r_data} !== ent[26:0]) begin
          n_fail++;
          $display("FAIL sb_pixel h=%0d v=%0d got=%h exp=%h", pop_h, pop_v,
                   {oHS, oVS, oBLANK_n, b_data, g_data, r_data}, ent[26:0]);
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  // Returns once the DUT outputs show pixel (x,y).
  task automatic wait_pix(input int x, input int y, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < BOUND; i++) begin
      @(posedge clk); #2;
      if (pop_h == x && pop_v == y) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL wait_pix timeout x=%0d y=%0d", x, y);
    end
  endtask

  // Returns at the start of line `row` of the model raster (mid-frame).
  task automatic wait_row(input int row);
    bit ok = 1'b0;
    for (int i = 0; i < BOUND; i++) begin
      @(posedge clk); #2;
      if (m_v == row && m_h == 0) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL wait_row timeout row=%0d", row);
    end
  endtask

  task automatic wait_frames(input int n);
    int target = m_frames + n;
    for (int i = 0; i < (n + 1) * HT * VT; i++) begin
      @(posedge clk); #2;
      if (m_frames >= target) break;
    end
  endtask

  task automatic set_buttons(input logic u, input logic d, input logic l, input logic r);
    mv_up = u; mv_down = d; mv_left = l; mv_right = r;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    int n;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if ({oHS, oVS, oBLANK_n} !== 3'b110) begin
      n_fail++; $display("FAIL reset_sync got=%b exp=110", {oHS, oVS, oBLANK_n});
    end
    n_checks++;
    if ({b_data, g_data, r_data} !== 24'h0) begin
      n_fail++; $display("FAIL reset_rgb got=%h exp=000000", {b_data, g_data, r_data});
    end
    n_checks++;
    if (img_addr !== 8'h0 || pal_addr !== 8'h0) begin
      n_fail++; $display("FAIL reset_addr got=%h/%h exp=00/00", img_addr, pal_addr);
    end
    @(posedge clk); #3;
    rst_n = 1'b1;
    // Edge counts from release: HS low at h=18 (+3 pipeline), VS low at v=13.
    n = 0;
    while (n < 100) begin @(posedge clk); #2; n++; if (oHS === 1'b0) break; end
    n_checks++;
    if (n != 21) begin n_fail++; $display("FAIL hs_first_low got=%0d exp=21", n); end
    while (n < 200) begin @(posedge clk); #2; n++; if (oHS === 1'b1) break; end
    n_checks++;
    if (n != 24) begin n_fail++; $display("FAIL hs_width got_end=%0d exp=24", n); end
    while (n < BOUND) begin @(posedge clk); #2; n++; if (oVS === 1'b0) break; end
    n_checks++;
    if (n != 315) begin n_fail++; $display("FAIL vs_first_low got=%0d exp=315", n); end
    while (n < BOUND) begin @(posedge clk); #2; n++; if (oVS === 1'b1) break; end
    n_checks++;
    if (n != 363) begin n_fail++; $display("FAIL vs_width got_end=%0d exp=363", n); end
    while (n < BOUND) begin @(posedge clk); #2; n++; if (oVS === 1'b0) break; end
    n_checks++;
    if (n != 723) begin n_fail++; $display("FAIL frame_period got=%0d exp=723", n); end
  endtask

  task automatic test_addr_palette;
    bit ok;
    wait_pix(5, 1, ok);
    if (ok) begin
      n_checks++;
      if ({oBLANK_n, b_data, g_data, r_data} !== {1'b1, 24'h15EA15}) begin
        n_fail++; $display("FAIL pix_5_1 got=%h exp=115ea15", {oBLANK_n, b_data, g_data, r_data});
      end
    end
    wait_pix(20, 1, ok);
    if (ok) begin
      n_checks++;
      if ({oHS, oBLANK_n, b_data, g_data, r_data} !== {2'b00, 24'h0}) begin
        n_fail++; $display("FAIL hblank_20_1 got=%h exp=0", {oHS, oBLANK_n, b_data, g_data, r_data});
      end
    end
    wait_pix(3, 14, ok);
    if (ok) begin
      n_checks++;
      if ({oVS, oBLANK_n, b_data, g_data, r_data} !== {2'b00, 24'h0}) begin
        n_fail++; $display("FAIL vblank_3_14 got=%h exp=0", {oVS, oBLANK_n, b_data, g_data, r_data});
      end
    end
  endtask

  task automatic test_sprite;
    bit ok;
    int xs[5]       = '{6, 7, 10, 11, 7};
    int ys[5]       = '{4, 4, 6, 4, 7};
    logic [23:0] ev[5] = '{24'h46B946, SPR, SPR, 24'h4BB44B, 24'h778877};
    for (int i = 0; i < 5; i++) begin
      wait_pix(xs[i], ys[i], ok);
      if (ok) begin
        n_checks++;
        if ({b_data, g_data, r_data} !== ev[i]) begin
          n_fail++;
          $display("FAIL sprite_pix x=%0d y=%0d got=%h exp=%h", xs[i], ys[i], {b_data, g_data, r_data}, ev[i]);
        end
      end
    end
  endtask

  task automatic test_move_left;
    bit ok;
    wait_row(5);
    set_buttons(0, 0, 1, 0);
    // One frame later the sprite sits at x=5.
    wait_pix(5, 4, ok);
    if (ok) begin
      n_checks++;
      if ({b_data, g_data, r_data} !== SPR) begin
        n_fail++; $display("FAIL left1_5_4 got=%h exp=%h", {b_data, g_data, r_data}, SPR);
      end
    end
    wait_pix(9, 4, ok);
    if (ok) begin
      n_checks++;
      if ({b_data, g_data, r_data} !== 24'h49B649) begin
        n_fail++; $display("FAIL left1_9_4 got=%h exp=49b649", {b_data, g_data, r_data});
      end
    end
    wait_frames(9);
    wait_row(5);
    set_buttons(0, 0, 0, 0);
    wait_pix(0, 4, ok);
    if (ok) begin
      n_checks++;
      if ({b_data, g_data, r_data} !== SPR) begin
        n_fail++; $display("FAIL left_clamp_0_4 got=%h exp=%h", {b_data, g_data, r_data}, SPR);
      end
    end
    wait_pix(4, 4, ok);
    if (ok) begin
      n_checks++;
      if ({b_data, g_data, r_data} !== 24'h44BB44) begin
        n_fail++; $display("FAIL left_clamp_4_4 got=%h exp=44bb44", {b_data, g_data, r_data});
      end
    end
  endtask

  task automatic test_move_down;
    bit ok;
    wait_row(5);
    set_buttons(0, 1, 0, 0);
    wait_frames(6);
    wait_row(5);
    set_buttons(0, 0, 0, 0);
    wait_pix(0, 8, ok);
    if (ok) begin
      n_checks++;
      if ({b_data, g_data, r_data} !== 24'h807F80) begin
        n_fail++; $display("FAIL down_clamp_0_8 got=%h exp=807f80", {b_data, g_data, r_data});
      end
    end
    wait_pix(0, 11, ok);
    if (ok) begin
      n_checks++;
      if ({b_data, g_data, r_data} !== SPR) begin
        n_fail++; $display("FAIL down_clamp_0_11 got=%h exp=%h", {b_data, g_data, r_data}, SPR);
      end
    end
  endtask

  task automatic test_simultaneous;
    bit ok;
    wait_row(5);
    set_buttons(1, 1, 1, 1);
    wait_frames(3);
    wait_row(5);
    set_buttons(0, 0, 0, 0);
    wait_pix(0, 9, ok);
    if (ok) begin
      n_checks++;
      if ({b_data, g_data, r_data} !== SPR) begin
        n_fail++; $display("FAIL both_0_9 got=%h exp=%h", {b_data, g_data, r_data}, SPR);
      end
    end
    wait_pix(4, 9, ok);
    if (ok) begin
      n_checks++;
      if ({b_data, g_data, r_data} !== 24'h946B94) begin
        n_fail++; $display("FAIL both_4_9 got=%h exp=946b94", {b_data, g_data, r_data});
      end
    end
  endtask

  task automatic test_mid_frame;
    bit ok;
    wait_row(5);
    set_buttons(0, 0, 0, 1);
    // Same frame: sprite still at x=0.
    wait_pix(0, 10, ok);
    if (ok) begin
      n_checks++;
      if ({b_data, g_data, r_data} !== SPR) begin
        n_fail++; $display("FAIL midframe_same got=%h exp=%h", {b_data, g_data, r_data}, SPR);
      end
    end
    wait_frames(1);
    wait_pix(0, 10, ok);
    if (ok) begin
      n_checks++;
      if ({b_data, g_data, r_data} !== 24'hA05FA0) begin
        n_fail++; $display("FAIL midframe_next_0 got=%h exp=a05fa0", {b_data, g_data, r_data});
      end
    end
    wait_pix(5, 10, ok);
    set_buttons(0, 0, 0, 0);
    if (ok) begin
      n_checks++;
      if ({b_data, g_data, r_data} !== SPR) begin
        n_fail++; $display("FAIL midframe_next_5 got=%h exp=%h", {b_data, g_data, r_data}, SPR);
      end
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    wait_pix(3, 2, ok);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({oHS, oVS, oBLANK_n, b_data, g_data, r_data} !== {3'b110, 24'h0}) begin
      n_fail++; $display("FAIL midreset_out got=%h exp=%h",
                         {oHS, oVS, oBLANK_n, b_data, g_data, r_data}, {3'b110, 24'h0});
    end
    n_checks++;
    if (img_addr !== 8'h0 || pal_addr !== 8'h0) begin
      n_fail++; $display("FAIL midreset_addr got=%h/%h exp=00/00", img_addr, pal_addr);
    end
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    wait_pix(2, 10, ok);
    if (ok) begin
      n_checks++;
      if ({b_data, g_data, r_data} !== 24'hA25DA2) begin
        n_fail++; $display("FAIL midreset_old_pos got=%h exp=a25da2", {b_data, g_data, r_data});
      end
    end
    wait_pix(6, 4, ok);
    if (ok) begin
      n_checks++;
      if ({b_data, g_data, r_data} !== 24'h46B946) begin
        n_fail++; $display("FAIL midreset_6_4 got=%h exp=46b946", {b_data, g_data, r_data});
      end
    end
    wait_pix(7, 4, ok);
    if (ok) begin
      n_checks++;
      if ({b_data, g_data, r_data} !== SPR) begin
        n_fail++; $display("FAIL midreset_7_4 got=%h exp=%h", {b_data, g_data, r_data}, SPR);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_addr_palette();
    test_sprite();
    test_move_left();
    test_move_down();
    test_simultaneous();
    test_mid_frame();
    test_reset_mid();
    repeat (HT * VT) @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_sprite_controller.md
Name: vga_sprite_controller

Overview:
- Parametrised successor of the fixed-640x480 VGA controller: integrates its own H/V timing generator, drives the external index-image ROM and palette ROM, and overlays a movable rectangular sprite.
- The moveUp/moveDown/moveLeft/moveRight buttons move the sprite by STEP pixels once per frame, clamped to the visible area.
- Sits between the board button inputs and the VGA DAC pins, pixel-clock domain only.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, HS pulse width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, VS pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- ADDR_W, 19, image ROM address width; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE
- IDX_W, 8, palette index width
- SPR_W, 32, sprite width (pixels)
- SPR_H, 32, sprite height (lines)
- STEP, 4, pixels moved per frame per axis
- INIT_X, 304, sprite X after reset
- INIT_Y, 224, sprite Y after reset
- SPR_BGR, 24'h0000FF, sprite colour, {b,g,r}

Ports:
- iVGA_CLK  in  1  pixel clock
- iRST_n  in  1  async active-low reset
- moveUp, moveDown, moveLeft, moveRight  in  1 each  raw button levels, asynchronous, active-high
- img_addr  out  ADDR_W  image ROM address
- img_index  in  IDX_W  ROM data, valid 1 clock after img_addr
- pal_addr  out  IDX_W  palette ROM address
- pal_bgr  in  24  palette data, valid 1 clock after pal_addr
- oHS, oVS  out  1 each  sync, active-low
- oBLANK_n  out  1  high in the visible area
- b_data, g_data, r_data  out  8 each  pixel colour

Behaviour:
- Reset (async, iRST_n=0):
  - hcnt=vcnt=0, img_addr=0, pal_addr=0.
  - Sprite at (INIT_X, INIT_Y).
  - Pipeline cleared.
  - Outputs: oHS=1, oVS=1, oBLANK_n=0, rgb=0.
- Timing counters:
  - hcnt runs 0..H_TOT-1, where H_TOT=H_ACTIVE+H_FP+H_SYNC+H_BP.
  - vcnt increments when hcnt wraps and runs 0..V_TOT-1.
  - Visible area: hcnt<H_ACTIVE and vcnt<V_ACTIVE.
  - HS low for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - VS low for vcnt in the equivalent window.
- Image address:
  - Stage 1 register: img_addr = vcnt*H_ACTIVE + hcnt when visible.
  - img_addr holds its last value when not visible.
  - img_addr is 0 at hcnt=0, vcnt=0.
- Pipeline, 3 clocks total; counter state at cycle t produces outputs at t+3:
  - t+1: img_addr registered.
  - t+2: img_index arrives; pal_addr <= img_index; sprite-hit and visibility flags delayed in step.
  - t+3: output register. If not visible, rgb=0. If sprite-hit, rgb=SPR_BGR. Otherwise rgb=pal_bgr.
  - oHS, oVS and oBLANK_n are delayed by the same 3 clocks, so they stay aligned with the pixel data.
- Sprite hit: curX <= hcnt < curX+SPR_W and curY <= vcnt < curY+SPR_H, evaluated on the stage-0 counters.
- Button inputs:
  - Each button goes through a 2-FF synchroniser.
  - Movement is applied only on frame_tick: the single clock where hcnt=H_TOT-1 and vcnt=V_TOT-1.
  - Position therefore never changes mid-frame; no tearing.
- Movement per axis, at frame_tick:
  - Up and Down both high: no Y change. Left and Right both high: no X change.
  - Up: curY = max(curY-STEP, 0).
  - Down: curY = min(curY+STEP, V_ACTIVE-SPR_H).
  - Left and Right follow the same rule with H_ACTIVE and SPR_W.
  - A held button moves STEP per frame. A button pulse shorter than one frame may be missed.
- Arithmetic:
  - Clamp computations are done one bit wider than the coordinate, so no wrap-around below 0 occurs.
  - X coordinate width = clog2(H_TOT); Y width = clog2(V_TOT).
- Mid-frame reset: everything returns to reset values immediately. Timing restarts at hcnt=vcnt=0 on the first clock after release.

Decomposition:
- Package vga_pkg holds:
  - clog2 function.
  - Default 640x480@60 timing constants.
  - Derived H_TOT/V_TOT localparam formulas.
  - BGR field slice constants.
- Natural sub-module: vga_timing_gen, which owns the hcnt/vcnt counters, HS/VS/visible flags and frame_tick.
- Synchroniser, movement/clamp logic and the colour pipeline stay in the top module.

Test Plan:
- Reset release, defaults:
  - First HS low edge appears 656+3 clocks after release; pulse is 96 clocks wide.
  - VS low spans exactly 2*800 clocks.
  - Frame period is 420000 clocks.
- Address and palette path:
  - Bench ROM returns index = addr[7:0]; palette returns {idx, ~idx, idx}.
  - Pixel (x=5, y=1) appears 3 clocks after its counter position with b=8'd133 (addr 645 mod 256), g=~133, r=133.
  - Blank pixels output 0.
- Sprite overlay:
  - No buttons pressed: pixels x∈[304,336), y∈[224,256) output 0000FF; pixels x=303 and x=336 output palette data.
- Movement and clamp:
  - Hold moveLeft for 80 frames: curX decrements by 4 per frame and reaches 0 after 76 frames, then stays 0.
  - Hold moveDown until the sprite stops: curY clamps at 448.
- Simultaneous and mid-frame events:
  - Up+Down held together: curY unchanged.
  - Button asserted mid-frame: position changes only at the next frame_tick.
  - Reset mid-line: all outputs return to reset values at once; sprite returns to (304,224).
